// File: rtl/fir_interpolator.sv
// rtl/fir_interpolator.sv - polyphase interpolating FIR with one time-shared MAC
module fir_interpolator #(
    parameter int INPUT_WIDTH  = 16,
    parameter int COEFF_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 26,
    parameter int INTERP       = 4,
    parameter int NUM_TAPS     = 32,
    parameter logic signed [COEFF_WIDTH-1:0] COEFFS [NUM_TAPS] = '{default: COEFF_WIDTH'(1)}
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     valid_in,
    output logic                                     ready_in,
    input  logic signed [INPUT_WIDTH-1:0]            din,
    output logic                                     valid_out,
    input  logic                                     ready_out,
    output logic signed [OUTPUT_WIDTH-1:0]           dout,
    output logic [(INTERP > 2 ? $clog2(INTERP) : 1)-1:0] phase_out,
    output logic                                     last_out
);
    localparam int P     = NUM_TAPS / INTERP;
    localparam int PW    = (INTERP > 2) ? $clog2(INTERP) : 1;
    localparam int TW    = (P > 1) ? $clog2(P) : 1;
    localparam int CW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int ACC_W = INPUT_WIDTH + COEFF_WIDTH + $clog2(P);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [TW-1:0]                   r_tap;
    logic [PW-1:0]                   r_phase;
    logic signed [INPUT_WIDTH-1:0]   r_dl [P];
    logic signed [ACC_W-1:0]         r_acc;
    logic signed [OUTPUT_WIDTH-1:0]  r_dout;
    logic [PW-1:0]                   r_phase_out;
    logic                            r_last;
    logic                            r_valid;
    logic                            r_ready;

    logic                            w_accept;
    logic                            w_last_tap;
    logic                            w_last_phase;
    logic [CW-1:0]                   w_cidx;
    logic signed [COEFF_WIDTH-1:0]   w_coeff;
    logic signed [INPUT_WIDTH-1:0]   w_x;
    logic signed [ACC_W-1:0]         w_prod;
    logic signed [ACC_W-1:0]         w_sum;
    logic signed [OUTPUT_WIDTH-1:0]  w_scaled;

    assign w_last_tap   = (r_tap == TW'(P - 1));
    assign w_last_phase = (r_phase == PW'(INTERP - 1));
    // Phase k uses every INTERP-th prototype coefficient starting at k.
    assign w_cidx       = CW'(int'(r_tap) * INTERP + int'(r_phase));
    assign w_coeff      = COEFFS[w_cidx];
    assign w_x          = r_dl[r_tap];
    assign w_prod       = ACC_W'(w_x) * ACC_W'(w_coeff);
    assign w_sum        = (r_tap == '0) ? w_prod : r_acc + w_prod;

    // Keep the top OUTPUT_WIDTH bits of the sum, or sign-extend when the output is wider.
    generate
        if (OUTPUT_WIDTH <= ACC_W) begin : g_trunc
            assign w_scaled = w_sum[ACC_W-1 -: OUTPUT_WIDTH];
        end else begin : g_ext
            assign w_scaled = OUTPUT_WIDTH'(w_sum);
        end
    endgenerate

    assign ready_in  = r_ready;
    assign valid_out = r_valid;
    assign dout      = r_dout;
    assign phase_out = r_phase_out;
    assign last_out  = r_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an input is taken only while ready_in is already high.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ready && valid_in) begin
                    w_accept     = 1'b1;
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                if (w_last_tap) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (ready_out) begin
                    w_state_next = w_last_phase ? S_IDLE : S_MAC;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Delay line, MAC accumulator, counters and the held output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < P; i++) begin
                r_dl[i] <= '0;
            end
            r_acc       <= '0;
            r_tap       <= '0;
            r_phase     <= '0;
            r_dout      <= '0;
            r_phase_out <= '0;
            r_last      <= 1'b0;
            r_valid     <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_ready <= (w_state_next == S_IDLE);
            if (w_accept) begin
                r_dl[0] <= din;
                for (int i = P - 1; i > 0; i--) begin
                    r_dl[i] <= r_dl[i-1];
                end
                r_tap   <= '0;
                r_phase <= '0;
            end
            if (r_state == S_MAC) begin
                r_acc <= w_sum;
                if (w_last_tap) begin
                    r_dout      <= w_scaled;
                    r_phase_out <= r_phase;
                    r_last      <= w_last_phase;
                    r_valid     <= 1'b1;
                end else begin
                    r_tap <= r_tap + TW'(1);
                end
            end
            if (r_state == S_OUT && ready_out) begin
                r_valid <= 1'b0;
                if (!w_last_phase) begin
                    r_phase <= r_phase + PW'(1);
                    r_tap   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_interpolator.sv
// tb/tb_fir_interpolator.sv - directed self-checking bench for fir_interpolator
module tb_fir_interpolator;
    localparam logic signed [7:0] C_RAMP [32] = '{
        8'sd1,  8'sd2,  8'sd3,  8'sd4,  8'sd5,  8'sd6,  8'sd7,  8'sd8,
        8'sd9,  8'sd10, 8'sd11, 8'sd12, 8'sd13, 8'sd14, 8'sd15, 8'sd16,
        8'sd17, 8'sd18, 8'sd19, 8'sd20, 8'sd21, 8'sd22, 8'sd23, 8'sd24,
        8'sd25, 8'sd26, 8'sd27, 8'sd28, 8'sd29, 8'sd30, 8'sd31, 8'sd32};
    localparam logic signed [7:0] C_ONE [32] = '{default: 8'sd1};
    localparam logic signed [7:0] C_NEG [32] = '{default: 8'sh80};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic valid_in = 1'b0;
    logic ready_out = 1'b1;
    logic signed [15:0] din_imp = '0;
    logic signed [15:0] din_dc  = '0;
    logic signed [15:0] din_neg = '0;

    logic rdy_imp, rdy_dc, rdy_n27, rdy_n26;
    logic vo_imp, vo_dc, vo_n27, vo_n26;
    logic lo_imp, lo_dc, lo_n27, lo_n26;
    logic [1:0] ph_imp, ph_dc, ph_n27, ph_n26;
    logic signed [26:0] dout_imp, dout_dc, dout_n27;
    logic signed [25:0] dout_n26;

    fir_interpolator #(.OUTPUT_WIDTH(27), .COEFFS(C_RAMP)) u_imp (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy_imp), .din(din_imp),
        .valid_out(vo_imp), .ready_out(ready_out), .dout(dout_imp),
        .phase_out(ph_imp), .last_out(lo_imp));
    fir_interpolator #(.OUTPUT_WIDTH(27), .COEFFS(C_ONE)) u_dc (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy_dc), .din(din_dc),
        .valid_out(vo_dc), .ready_out(ready_out), .dout(dout_dc),
        .phase_out(ph_dc), .last_out(lo_dc));
    fir_interpolator #(.OUTPUT_WIDTH(27), .COEFFS(C_NEG)) u_n27 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy_n27), .din(din_neg),
        .valid_out(vo_n27), .ready_out(ready_out), .dout(dout_n27),
        .phase_out(ph_n27), .last_out(lo_n27));
    fir_interpolator #(.COEFFS(C_NEG)) u_n26 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy_n26), .din(din_neg),
        .valid_out(vo_n26), .ready_out(ready_out), .dout(dout_n26),
        .phase_out(ph_n26), .last_out(lo_n26));

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] x);
        int i = 0;
        @(negedge clk);
        while (!rdy_imp && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("send_ready", 32'(rdy_imp), 1);
        din_imp  = x;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        din_imp  = '0;
    endtask

    task automatic expect_out(input string tag, input int e_dout, input int e_ph, input int e_last);
        int i = 0;
        while (!vo_imp && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_valid"}, 32'(vo_imp), 1);
        chk({tag, "_dout"}, 32'(dout_imp), e_dout);
        chk({tag, "_phase"}, 32'(ph_imp), e_ph);
        chk({tag, "_last"}, 32'(lo_imp), e_last);
        if (ready_out) @(negedge clk);
    endtask

    initial begin
        int n_in = 0;
        int n_out = 0;
        int acc_c [10];
        int prev_out_c = 0;
        int k;

        // Reset state after two reset edges.
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(vo_imp), 0);
        chk("rst_dout", 32'(dout_imp), 0);
        chk("rst_phase", 32'(ph_imp), 0);
        chk("rst_last", 32'(lo_imp), 0);
        chk("rst_ready", 32'(rdy_imp), 0);
        rst = 1'b0;

        // Impulse / DC / negative full scale in lockstep, valid_in held high, ready_out high.
        ready_out = 1'b1;
        for (int c = 0; c < 600 && n_out < 40; c++) begin
            @(negedge clk);
            valid_in = (n_in < 10);
            din_imp  = (n_in == 0) ? 16'sd1 : 16'sd0;
            din_dc   = 16'sd100;
            din_neg  = -16'sd32768;
            if (vo_imp) begin
                k = (n_out / 4 + 1 > 8) ? 8 : n_out / 4 + 1;
                chk("imp_dout", 32'(dout_imp), (n_out < 32) ? n_out + 1 : 0);
                chk("imp_phase", 32'(ph_imp), n_out % 4);
                chk("imp_last", 32'(lo_imp), (n_out % 4 == 3) ? 1 : 0);
                chk("dc_dout", 32'(dout_dc), 100 * k);
                chk("neg27_dout", 32'(dout_n27), 4194304 * k);
                chk("neg26_dout", 32'(dout_n26), 2097152 * k);
                if (n_out % 4 == 0) chk("lat_first", c, acc_c[n_out / 4] + 9);
                else                chk("lat_phase", c, prev_out_c + 9);
                prev_out_c = c;
                n_out++;
            end
            if (rdy_imp && valid_in) begin
                if (n_in > 0) chk("ready_period", c - acc_c[n_in - 1], 37);
                acc_c[n_in] = c;
                n_in++;
            end
        end
        valid_in = 1'b0;
        chk("main_inputs", n_in, 10);
        chk("main_outputs", n_out, 40);

        // Backpressure: stall the phase-1 output for ten cycles with a din pulse during the stall.
        ready_out = 1'b1;
        send(16'sd1);
        expect_out("bp_ph0", 1, 0, 0);
        ready_out = 1'b0;
        expect_out("bp_ph1", 2, 1, 0);
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            valid_in = (s == 4);
            din_imp  = (s == 4) ? 16'sd5 : 16'sd0;
            chk("bp_hold_valid", 32'(vo_imp), 1);
            chk("bp_hold_dout", 32'(dout_imp), 2);
            chk("bp_hold_phase", 32'(ph_imp), 1);
            chk("bp_hold_ready", 32'(rdy_imp), 0);
        end
        @(negedge clk);
        valid_in  = 1'b0;
        din_imp   = '0;
        ready_out = 1'b1;
        expect_out("bp_release", 2, 1, 0);
        expect_out("bp_ph2", 3, 2, 0);
        expect_out("bp_ph3", 4, 3, 1);

        // Reset during MAC of phase 2; history x[n-1]=1 makes pre-reset outputs h[k]+h[k+4].
        send(16'sd1);
        expect_out("hist_ph0", 6, 0, 0);
        expect_out("hist_ph1", 8, 1, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 32'(vo_imp), 0);
        chk("mrst_ready", 32'(rdy_imp), 0);
        chk("mrst_dout", 32'(dout_imp), 0);
        chk("mrst_phase", 32'(ph_imp), 0);
        chk("mrst_last", 32'(lo_imp), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_ready_after", 32'(rdy_imp), 1);
        chk("mrst_valid_after", 32'(vo_imp), 0);
        send(16'sd1);
        expect_out("post_ph0", 1, 0, 0);
        expect_out("post_ph1", 2, 1, 0);
        expect_out("post_ph2", 3, 2, 0);
        expect_out("post_ph3", 4, 3, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/fir_interpolator.md
Name: fir_interpolator

Overview:
- Polyphase interpolating FIR. Upsamples by INTERP and filters with a NUM_TAPS coefficient set.
- One MAC is time-multiplexed across taps.
- Sits on the transmit/synthesis side of the datapath, opposite the parallel decimating/receive FIR. It accepts one sample per handshake and emits INTERP filtered samples through a valid/ready output.

Parameters:
INPUT_WIDTH, 16, input sample width, signed two's complement
COEFF_WIDTH, 8, coefficient width, signed
OUTPUT_WIDTH, 26, output sample width, signed
INTERP, 4, interpolation factor L, must be ≥2
NUM_TAPS, 32, prototype filter length, must be a multiple of INTERP
COEFFS, '{NUM_TAPS entries}, signed coefficients h[0..NUM_TAPS-1], prototype order

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
valid_in  in  1  din valid
ready_in  out  1  block can accept din
din  in  INPUT_WIDTH  input sample x[n]
valid_out  out  1  dout valid
ready_out  in  1  downstream accepts dout
dout  out  OUTPUT_WIDTH  output sample y[n*INTERP+k]
phase_out  out  max(1,$clog2(INTERP))  phase index k of dout
last_out  out  1  high with valid_out when k == INTERP-1

Behaviour:
- Derived values:
  - P = NUM_TAPS/INTERP taps per phase.
  - ACC_W = INPUT_WIDTH+COEFF_WIDTH+$clog2(P).
- Delay line: P registers x[n]..x[n-P+1]. On accept, din shifts into entry 0 and the oldest entry drops.
- Phase k output: y = sum over m=0..P-1 of h[m*INTERP+k]*x[n-m]. Signed full-precision accumulate in ACC_W bits.
- Output width rule:
  - OUTPUT_WIDTH ≤ ACC_W: dout = acc[ACC_W-1 : ACC_W-OUTPUT_WIDTH], which truncates LSBs with no rounding.
  - Otherwise: dout = sign-extended acc.
- FSM states IDLE, MAC, OUT. Counters: tap (0..P-1), phase (0..INTERP-1).
- IDLE:
  - ready_in=1.
  - On valid_in: shift delay line, tap←0, phase←0, go to MAC.
- MAC:
  - One product per cycle, h[tap*INTERP+phase]*x[n-tap].
  - tap==0: acc←product.
  - Otherwise: acc←acc+product.
  - At tap==P-1: dout←final sum (width rule applied), phase_out←phase, last_out←(phase==INTERP-1), valid_out←1, go to OUT.
- OUT:
  - dout, phase_out, last_out and valid_out are held stable while ready_out=0.
  - On ready_out: valid_out←0.
    - If phase==INTERP-1, go to IDLE.
    - Otherwise phase←phase+1, tap←0, go to MAC.
- ready_in is 1 only in IDLE. ready_in is a registered function of state.
- valid_in while not ready is ignored, with no side effects.
- Latency: valid_out rises P clock edges after the accepting edge.
  - Each later phase follows P cycles after the previous handshake.
  - Minimum cycles per input with ready_out tied high: 1+INTERP*(P+1). This is 37 with the defaults.
- Reset (any state, including mid-MAC or while OUT is stalled):
  - Next state IDLE; delay line and acc cleared; tap and phase cleared.
  - valid_out=0, dout=0, phase_out=0, last_out=0, ready_in=0 during the reset cycle, then 1.
  - A stalled output is discarded.
- Overflow: none possible within ACC_W for any coefficient set. The accumulator is never saturated.

Test Plan:
- Impulse response. Override OUTPUT_WIDTH=27 (ACC_W). Set COEFFS=1..32 and ready_out=1. Feed din=1 followed by seven zeros. Required output: 32 samples equal to 1,2,...,32 in order, with phase_out cycling 0..3 and last_out set on every 4th sample.
- Step/DC. Use COEFFS all 1 and din=100 repeatedly. From the 8th input onward every output equals 800. Outputs before that ramp 100,200,...,800, with all four phases equal per input.
- Negative full scale. Use din=-32768 with COEFFS all -128 (OUTPUT_WIDTH=27). Steady-state output equals +33554432 with no wrap. With default OUTPUT_WIDTH=26, dout equals 16777216 (1-LSB truncation).
- Backpressure. Hold ready_out=0 for 10 cycles at the phase-1 output. dout, phase_out=1 and valid_out stay constant. ready_in stays 0 throughout, and a din pulse during the stall is not absorbed. Output values are unchanged versus the no-stall run.
- Handshake timing. With ready_out=1 and valid_in held high, ready_in pulses once every 37 cycles. The first valid_out occurs exactly 8 edges after the accept.
- Reset mid-operation. Assert rst for 1 cycle during MAC of phase 2. valid_out=0 immediately. The next input after reset produces outputs as if the history were all zero (the impulse test reproduces h[0..3] exactly).
